// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives prog_ctr into a combinational ROM, registers mach_code as instr.
// Optional fetched-instruction counter on fetch_count is enabled by defining INSTR_FETCH_PERF_EN.
module instr_fetch #(
    parameter int D = 12,
    parameter int W = 9,
    parameter logic [W-1:0] HALT_CODE = 9'h1FF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stall,
    input  logic         branch_en,
    input  logic         branch_rel,
    input  logic [D-1:0] branch_target,
    input  logic [W-1:0] mach_code,
    output logic [D-1:0] prog_ctr,
    output logic [W-1:0] instr,
    output logic         instr_valid,
    output logic         halted,
    output logic [15:0]  fetch_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    logic [1:0] state;
    logic       capture;
    logic       restart;

    // instr_valid is a one-cycle strobe with no ready: decode must take instr on every cycle it is high.
    assign capture = (state == S_FETCH) && !stall && !branch_en;
    assign restart = start && (state != S_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            prog_ctr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        prog_ctr <= '0;
                    end
                end
                S_FETCH: begin
                    if (!stall) begin
                        if (branch_en) begin
                            // The instruction at the old PC is squashed, never captured.
                            if (branch_rel) begin
                                prog_ctr <= prog_ctr + branch_target;
                            end else begin
                                prog_ctr <= branch_target;
                            end
                        end else begin
                            instr       <= mach_code;
                            instr_valid <= 1'b1;
                            if (mach_code == HALT_CODE) begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end else begin
                                prog_ctr <= prog_ctr + 1'b1;
                            end
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state    <= S_FETCH;
                        prog_ctr <= '0;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= '0;
        end else if (capture && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule
